// File: rtl/result_streamer.sv
// Drains 4x4 result matrices from output memory into a tagged valid/ready stream.
// Start to first word is 3 cycles; a 2-entry skid buffer sustains 1 word/cycle and holds the head stable under stall.
module result_streamer #(
   parameter int DEPTH    = 2,
   parameter int MAX_MATS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  num_mats,
   output logic        mem_ren,
   output logic [6:0]  mem_addr,
   input  logic [31:0] mem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  out_mat,
   output logic [1:0]  out_row,
   output logic [1:0]  out_col,
   output logic        out_last,
   output logic        out_final,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   typedef struct packed {
      logic [31:0] dat;
      logic [6:0]  addr;
      logic        fin;
   } entry_t;

   localparam logic [3:0] MAX_N = 4'(MAX_MATS);

   state_t      state_q, state_d;
   logic [3:0]  n_q, n_d;
   logic [7:0]  rd_cnt_q, rd_cnt_d;
   logic        done_q, done_d;
   logic        rd_vld_q;
   logic [6:0]  rd_addr_q;
   logic        rd_fin_q;
   entry_t      ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]  occ_q, occ_d;

   logic [7:0]  total;
   logic        rd_is_last;
   logic        pop;
   logic [2:0]  lvl;
   entry_t      new_e;

   assign total      = {n_q, 4'b0000};
   assign rd_is_last = (rd_cnt_q == total - 8'd1);
   assign pop        = out_valid & out_ready;
   // Occupancy plus in-flight reads, net of this cycle's pop, so full rate is kept without overflow.
   assign lvl        = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop};
   assign mem_ren    = (state_q == DRAIN) && (lvl < 3'(DEPTH));
   assign mem_addr   = mem_ren ? rd_cnt_q[6:0] : 7'd0;
   assign new_e      = {mem_data, rd_addr_q, rd_fin_q};

   assign out_valid  = (occ_q != 2'd0);
   assign out_data   = ent0_q.dat;
   assign out_mat    = ent0_q.addr[6:4];
   assign out_row    = ent0_q.addr[3:2];
   assign out_col    = ent0_q.addr[1:0];
   assign out_last   = &ent0_q.addr[3:0];
   assign out_final  = ent0_q.fin;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_mats == 4'd0) begin
                  done_d = 1'b1;
               end else begin
                  n_d      = (num_mats > MAX_N) ? MAX_N : num_mats;
                  rd_cnt_d = 8'd0;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (mem_ren) begin
               rd_cnt_d = rd_cnt_q + 8'd1;
               if (rd_is_last) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (pop && out_final) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({rd_vld_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = new_e;
            else               ent1_d = new_e;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               ent0_d = new_e;
            end else begin
               ent0_d = ent1_q;
               ent1_d = new_e;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         n_q       <= 4'd0;
         rd_cnt_q  <= 8'd0;
         done_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_addr_q <= 7'd0;
         rd_fin_q  <= 1'b0;
         ent0_q    <= '0;
         ent1_q    <= '0;
         occ_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         rd_cnt_q  <= rd_cnt_d;
         done_q    <= done_d;
         rd_vld_q  <= mem_ren;
         rd_addr_q <= mem_addr;
         rd_fin_q  <= mem_ren && rd_is_last;
         ent0_q    <= ent0_d;
         ent1_q    <= ent1_d;
         occ_q     <= occ_d;
      end
   end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001: Parameter DEPTH, default 2: skid-buffer entries; legal value is 2 only.
REQ-002: Parameter MAX_MATS, default 8: maximum number of 4x4 result matrices held in output memory.
REQ-003: clk  in  1  single clock; all state changes on the rising edge.
REQ-004: rst  in  1  reset, asynchronous and active-high.
REQ-005: start  in  1  one-cycle pulse that begins a drain.
REQ-006: num_mats  in  4  number of matrices to drain, sampled with start.
REQ-007: mem_ren  out  1  output-memory read enable.
REQ-008: mem_addr  out  7  output-memory word address.
REQ-009: mem_data  in  32  output-memory read data, valid in the cycle after mem_ren.
REQ-010: out_valid  out  1  result word available.
REQ-011: out_ready  in  1  downstream accepts the word.
REQ-012: out_data  out  32  result word (one C element).
REQ-013: out_mat  out  3  matrix index of the word.
REQ-014: out_row  out  2  row index, equal to element index bits [3:2].
REQ-015: out_col  out  2  column index, equal to element index bits [1:0].
REQ-016: out_last  out  1  high with element 15 of each matrix.
REQ-017: out_final  out  1  high with the last word of the drain.
REQ-018: busy  out  1  drain in progress.
REQ-019: done  out  1  one-cycle pulse when the drain completes.

Function
REQ-020: The block SHALL have states IDLE, DRAIN and FLUSH; a drain SHALL run IDLE->DRAIN on start, DRAIN->FLUSH after the last read issues, and FLUSH->IDLE on the final handshake.
REQ-021: In IDLE, start=1 SHALL latch n = min(num_mats, MAX_MATS), clear the read counter, and set busy=1 in the next cycle.
REQ-022: start SHALL be ignored while busy=1.
REQ-023: start with num_mats=0 SHALL issue no reads, keep busy=0, and pulse done in the next cycle.
REQ-024: Read k, for k = 0..16n-1, SHALL use mem_addr = k: matrix k[6:4], element k[3:0]; mem_addr SHALL never exceed 16n-1, so there is no wrap.
REQ-025: mem_ren SHALL assert only when (buffer occupancy + reads in flight) < DEPTH, so no returning word is ever dropped.
REQ-026: A word read with mem_ren in cycle t SHALL be written into the buffer at the end of cycle t+1, together with its mat/row/col/last/final tags.
REQ-027: The buffer head SHALL drive out_* directly; out_valid = (occupancy != 0).
REQ-028: A handshake (out_valid & out_ready) SHALL pop the head; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-029: While out_valid=1 and out_ready=0, out_data and all tags SHALL hold stable.
REQ-030: With out_ready held at 1, throughput SHALL be 1 word/cycle.
REQ-031: Latency SHALL be: start sampled at edge T -> mem_ren=1, mem_addr=0 during cycle T+1 -> out_valid=1 with word 0 during cycle T+3.
REQ-032: Words SHALL emerge in strictly increasing address order, none skipped or duplicated.
REQ-033: out_last SHALL be 1 exactly when the element index is 15; out_final SHALL be 1 only for address 16n-1.
REQ-034: The final handshake SHALL clear busy and pulse done in the following cycle.
REQ-035: The state SHALL return to IDLE after done, with occupancy 0 and no reads in flight.

Reset
REQ-036: rst=1 SHALL force, asynchronously: state IDLE, mem_ren=0, mem_addr=0, out_valid=0, out_data=0, out_mat=0, out_row=0, out_col=0, out_last=0, out_final=0, busy=0, done=0, occupancy 0, in-flight count 0.
REQ-037: rst asserted mid-drain SHALL discard buffered and in-flight words; a read returning after rst deasserts SHALL be ignored.
REQ-038: After rst, the block SHALL accept a new start on the first rising edge with rst=0.

Verification
REQ-039: Memory preloaded mem[a]=a+100; num_mats=1; out_ready=1 -> 16 consecutive words 100..115 starting cycle T+3, out_last and out_final only on word 115, done one cycle later.
REQ-040: num_mats=8, out_ready toggling with a 1/0 pattern -> 128 words 100..227 in order, out_last on every 16th word, out_mat stepping 0..7, data held stable on every stalled cycle.
REQ-041: num_mats=0 -> no mem_ren, done pulse the next cycle, busy stays 0; num_mats=12 -> exactly 128 words (clamped to 8 matrices).
REQ-042: out_ready=0 for 20 cycles after start -> occupancy saturates at 2, mem_ren stays 0 while saturated, no word lost once ready rises.
REQ-043: rst pulsed after 5 handshakes of a 2-matrix drain, then start with num_mats=1 -> outputs at reset values during rst; the new drain returns words 100..115 only, with no stale word.
REQ-044: start re-pulsed during a busy drain -> ignored; word count and done timing unchanged.
